// File: rtl/iso14443a_pkg.sv
// rtl/iso14443a_pkg.sv - shared ISO14443A constants, scheduler state type and counter width helper
package iso14443a_pkg;

    // Carrier cycles in one late-response grid step (one bit period).
    localparam int GRID_TICKS_DEFAULT = 128;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        WAIT_FDT,
        GRID,
        TX
    } tx_sched_state_t;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_scheduler_grid_timer.sv
// rtl/tx_scheduler_grid_timer.sv - late-response tick/grid counters with wrap and terminal flags
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_en       - counting enable; counters are held at zero while low
//   o_wrap     - enabled cycle on which the tick counter is at GRID_TICKS-1
//   o_last     - grid counter is at MAX_GRIDS-1
module grid_timer
    import iso14443a_pkg::*;
#(
    parameter int GRID_TICKS = GRID_TICKS_DEFAULT,
    parameter int MAX_GRIDS  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_wrap,
    output logic o_last
);

    localparam int TW = cnt_width(GRID_TICKS);
    localparam int GW = cnt_width(MAX_GRIDS);

    logic [TW-1:0] r_tick;
    logic [GW-1:0] r_grid;
    logic          w_tick_wrap;

    assign w_tick_wrap = (r_tick == TW'(GRID_TICKS - 1));
    assign o_wrap      = i_en & w_tick_wrap;
    assign o_last      = (r_grid == GW'(MAX_GRIDS - 1));

    // Holding at zero while disabled guarantees both counters read 0 in
    // the first cycle of every grid phase without a separate clear input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
            r_grid <= '0;
        end else if (!i_en) begin
            r_tick <= '0;
            r_grid <= '0;
        end else if (w_tick_wrap) begin
            r_tick <= '0;
            r_grid <= o_last ? '0 : r_grid + 1'b1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - reply scheduler: pause detection, FDT / late-grid release of the transmitter
//
// Ports:
//   clk, rst_n            - carrier clock, asynchronous active-low reset
//   pause_n_synchronised  - reader pause, low during a pause
//   rx_eoc / rx_error     - frame received valid / invalid (pulses)
//   fdt_trigger           - nominal reply instant (pulse)
//   resp_ready            - response loaded (level)
//   tx_done               - transmitter finished (pulse)
//   tx_go                 - start transmission (pulse)
//   tx_busy               - transmitter owned by this reply
//   resp_late             - tx_go issued on a late grid step (pulse)
//   resp_timeout          - pending response abandoned (pulse)
module tx_scheduler
    import iso14443a_pkg::*;
#(
    parameter int GRID_TICKS = GRID_TICKS_DEFAULT,
    parameter int MAX_GRIDS  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pause_n_synchronised,
    input  logic rx_eoc,
    input  logic rx_error,
    input  logic fdt_trigger,
    input  logic resp_ready,
    input  logic tx_done,
    output logic tx_go,
    output logic tx_busy,
    output logic resp_late,
    output logic resp_timeout
);

    tx_sched_state_t r_state;
    logic            r_pause_prev;
    logic            r_tx_go;
    logic            r_tx_busy;
    logic            r_resp_late;
    logic            r_resp_timeout;

    logic            w_pause_fall;
    logic            w_grid_en;
    logic            w_grid_wrap;
    logic            w_grid_last;

    assign w_pause_fall = r_pause_prev & ~pause_n_synchronised;
    assign w_grid_en    = (r_state == GRID);

    grid_timer #(
        .GRID_TICKS (GRID_TICKS),
        .MAX_GRIDS  (MAX_GRIDS)
    ) u_grid_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_grid_en),
        .o_wrap (w_grid_wrap),
        .o_last (w_grid_last)
    );

    assign tx_go        = r_tx_go;
    assign tx_busy      = r_tx_busy;
    assign resp_late    = r_resp_late;
    assign resp_timeout = r_resp_timeout;

    // tx_busy is set and cleared on exactly the transitions into and out of
    // TX, so it always mirrors (state == TX) one-for-one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pause_prev   <= 1'b1;
            r_tx_go        <= 1'b0;
            r_tx_busy      <= 1'b0;
            r_resp_late    <= 1'b0;
            r_resp_timeout <= 1'b0;
        end else begin
            r_pause_prev   <= pause_n_synchronised;
            r_tx_go        <= 1'b0;
            r_resp_late    <= 1'b0;
            r_resp_timeout <= 1'b0;

            // A new reader pause starts a new frame and drops any pending
            // reply; an ongoing transmission cannot be interrupted.
            if (w_pause_fall && (r_state != TX)) begin
                r_state <= RX;
            end else begin
                case (r_state)
                    IDLE: begin
                    end
                    RX: begin
                        if (rx_eoc) begin
                            r_state <= WAIT_FDT;
                        end else if (rx_error) begin
                            r_state <= IDLE;
                        end
                    end
                    WAIT_FDT: begin
                        if (fdt_trigger) begin
                            if (resp_ready) begin
                                r_state   <= TX;
                                r_tx_go   <= 1'b1;
                                r_tx_busy <= 1'b1;
                            end else begin
                                r_state <= GRID;
                            end
                        end
                    end
                    GRID: begin
                        if (w_grid_wrap) begin
                            if (resp_ready) begin
                                r_state     <= TX;
                                r_tx_go     <= 1'b1;
                                r_tx_busy   <= 1'b1;
                                r_resp_late <= 1'b1;
                            end else if (w_grid_last) begin
                                r_state        <= IDLE;
                                r_resp_timeout <= 1'b1;
                            end
                        end
                    end
                    TX: begin
                        if (tx_done) begin
                            r_state   <= IDLE;
                            r_tx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb/tb_tx_scheduler.sv - directed self-checking bench for tx_scheduler
module tb_tx_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic pause_n;
    logic rx_eoc;
    logic rx_error;
    logic fdt_trigger;
    logic resp_ready;
    logic tx_done;
    logic tx_go;
    logic tx_busy;
    logic resp_late;
    logic resp_timeout;

    int total = 0;
    int bad   = 0;

    // Window observations, cycle numbers relative to the trigger cycle T.
    int w_first_go;
    int w_go_cnt;
    int w_late_cnt;
    int w_late_go;
    int w_first_to;
    int w_to_cnt;

    always #5 clk = ~clk;

    tx_scheduler #(
        .GRID_TICKS (128),
        .MAX_GRIDS  (8)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pause_n_synchronised (pause_n),
        .rx_eoc               (rx_eoc),
        .rx_error             (rx_error),
        .fdt_trigger          (fdt_trigger),
        .resp_ready           (resp_ready),
        .tx_done              (tx_done),
        .tx_go                (tx_go),
        .tx_busy              (tx_busy),
        .resp_late            (resp_late),
        .resp_timeout         (resp_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pause();
        pause_n = 1'b0;
        step();
        pause_n = 1'b1;
        step();
    endtask

    task automatic pulse_eoc();
        rx_eoc = 1'b1;
        step();
        rx_eoc = 1'b0;
    endtask

    task automatic pulse_error();
        rx_error = 1'b1;
        step();
        rx_error = 1'b0;
    endtask

    // After this returns the bench sits in cycle T+1.
    task automatic trigger();
        fdt_trigger = 1'b1;
        step();
        fdt_trigger = 1'b0;
    endtask

    task automatic finish_tx();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
    endtask

    // Observes cycles T+1 .. T+ncycles; resp_ready is high from cycle
    // ready_at on, and pause_n is low only in cycle pause_at.
    task automatic run_window(input int ready_at, input int pause_at, input int ncycles);
        w_first_go = 0;
        w_go_cnt   = 0;
        w_late_cnt = 0;
        w_late_go  = 0;
        w_first_to = 0;
        w_to_cnt   = 0;
        for (int c = 1; c <= ncycles; c++) begin
            resp_ready = (c >= ready_at) ? 1'b1 : 1'b0;
            pause_n    = (c == pause_at) ? 1'b0 : 1'b1;
            if (tx_go === 1'b1) begin
                w_go_cnt++;
                if (w_first_go == 0) w_first_go = c;
                if (resp_late === 1'b1) w_late_go++;
            end
            if (resp_late === 1'b1) w_late_cnt++;
            if (resp_timeout === 1'b1) begin
                w_to_cnt++;
                if (w_first_to == 0) w_first_to = c;
            end
            step();
        end
        pause_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++; if (tx_go !== 1'b0) begin bad++; $display("FAIL reset_tx_go: got %b expected 0", tx_go); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        total++; if (resp_late !== 1'b0) begin bad++; $display("FAIL reset_resp_late: got %b expected 0", resp_late); end
        total++; if (resp_timeout !== 1'b0) begin bad++; $display("FAIL reset_resp_timeout: got %b expected 0", resp_timeout); end
        rst_n = 1'b1;
        step();
        // Without a pause, rx_eoc and fdt_trigger must not leave IDLE.
        resp_ready = 1'b1;
        pulse_eoc();
        trigger();
        run_window(1, 0, 6);
        total++; if (w_go_cnt !== 0) begin bad++; $display("FAIL idle_no_pause_go: got %0d expected 0", w_go_cnt); end
        resp_ready = 1'b0;
    endtask

    task automatic test_nominal();
        do_pause();
        pulse_eoc();
        resp_ready = 1'b1;
        trigger();
        total++; if (tx_go !== 1'b1) begin bad++; $display("FAIL nominal_go_t1: got %b expected 1", tx_go); end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL nominal_busy_t1: got %b expected 1", tx_busy); end
        total++; if (resp_late !== 1'b0) begin bad++; $display("FAIL nominal_late_t1: got %b expected 0", resp_late); end
        step();
        total++; if (tx_go !== 1'b0) begin bad++; $display("FAIL nominal_go_t2: got %b expected 0", tx_go); end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL nominal_busy_t2: got %b expected 1", tx_busy); end
        resp_ready = 1'b0;
        step();
        step();
        tx_done = 1'b1;
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL nominal_busy_done_cycle: got %b expected 1", tx_busy); end
        step();
        tx_done = 1'b0;
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL nominal_busy_after_done: got %b expected 0", tx_busy); end
        step();
    endtask

    task automatic test_mid_tx_reset();
        do_pause();
        pulse_eoc();
        resp_ready = 1'b1;
        trigger();
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx_go !== 1'b0) begin bad++; $display("FAIL midtx_reset_go: got %b expected 0", tx_go); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL midtx_reset_busy: got %b expected 0", tx_busy); end
        step();
        step();
        rst_n = 1'b1;
        step();
        trigger();
        run_window(1, 0, 6);
        total++; if (w_go_cnt !== 0) begin bad++; $display("FAIL midtx_reset_trigger_go: got %0d expected 0", w_go_cnt); end
        resp_ready = 1'b0;
    endtask

    task automatic test_late();
        do_pause();
        pulse_eoc();
        resp_ready = 1'b0;
        trigger();
        run_window(300, 0, 400);
        total++; if (w_first_go !== 385) begin bad++; $display("FAIL late_go_cycle: got %0d expected 385", w_first_go); end
        total++; if (w_go_cnt !== 1) begin bad++; $display("FAIL late_go_count: got %0d expected 1", w_go_cnt); end
        total++; if (w_late_go !== 1) begin bad++; $display("FAIL late_flag_with_go: got %0d expected 1", w_late_go); end
        total++; if (w_late_cnt !== 1) begin bad++; $display("FAIL late_flag_count: got %0d expected 1", w_late_cnt); end
        total++; if (w_to_cnt !== 0) begin bad++; $display("FAIL late_timeout_count: got %0d expected 0", w_to_cnt); end
        resp_ready = 1'b0;
        finish_tx();
    endtask

    task automatic test_timeout();
        do_pause();
        pulse_eoc();
        resp_ready = 1'b0;
        trigger();
        run_window(100000, 0, 1030);
        total++; if (w_first_to !== 1025) begin bad++; $display("FAIL timeout_cycle: got %0d expected 1025", w_first_to); end
        total++; if (w_to_cnt !== 1) begin bad++; $display("FAIL timeout_count: got %0d expected 1", w_to_cnt); end
        total++; if (w_go_cnt !== 0) begin bad++; $display("FAIL timeout_go_count: got %0d expected 0", w_go_cnt); end
        resp_ready = 1'b1;
        trigger();
        run_window(1, 0, 6);
        total++; if (w_go_cnt !== 0) begin bad++; $display("FAIL timeout_idle_go: got %0d expected 0", w_go_cnt); end
        resp_ready = 1'b0;
    endtask

    task automatic test_last_grid_ready();
        do_pause();
        pulse_eoc();
        resp_ready = 1'b0;
        trigger();
        run_window(1020, 0, 1030);
        total++; if (w_first_go !== 1025) begin bad++; $display("FAIL lastgrid_go_cycle: got %0d expected 1025", w_first_go); end
        total++; if (w_late_go !== 1) begin bad++; $display("FAIL lastgrid_late_flag: got %0d expected 1", w_late_go); end
        total++; if (w_to_cnt !== 0) begin bad++; $display("FAIL lastgrid_timeout_count: got %0d expected 0", w_to_cnt); end
        resp_ready = 1'b0;
        finish_tx();
    endtask

    task automatic test_pause_in_grid();
        do_pause();
        pulse_eoc();
        resp_ready = 1'b0;
        trigger();
        run_window(60, 50, 400);
        total++; if (w_go_cnt !== 0) begin bad++; $display("FAIL grid_pause_go: got %0d expected 0", w_go_cnt); end
        total++; if (w_to_cnt !== 0) begin bad++; $display("FAIL grid_pause_timeout: got %0d expected 0", w_to_cnt); end
        pulse_error();
        step();
        trigger();
        run_window(1, 0, 6);
        total++; if (w_go_cnt !== 0) begin bad++; $display("FAIL grid_pause_error_go: got %0d expected 0", w_go_cnt); end
        resp_ready = 1'b0;
    endtask

    task automatic test_eoc_with_pause();
        pause_n = 1'b0;
        rx_eoc  = 1'b1;
        step();
        pause_n = 1'b1;
        rx_eoc  = 1'b0;
        step();
        resp_ready = 1'b1;
        trigger();
        run_window(1, 0, 5);
        total++; if (w_go_cnt !== 0) begin bad++; $display("FAIL eoc_pause_trigger_go: got %0d expected 0", w_go_cnt); end
        // Still in RX: a clean rx_eoc now arms the reply.
        pulse_eoc();
        trigger();
        total++; if (tx_go !== 1'b1) begin bad++; $display("FAIL eoc_pause_rearm_go: got %b expected 1", tx_go); end
        resp_ready = 1'b0;
        finish_tx();
    endtask

    task automatic test_back_to_back();
        do_pause();
        pulse_eoc();
        resp_ready = 1'b1;
        trigger();
        resp_ready = 1'b0;
        pause_n = 1'b0;
        step();
        pause_n = 1'b1;
        step();
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL tx_pause_busy: got %b expected 1", tx_busy); end
        finish_tx();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL tx_pause_done_busy: got %b expected 0", tx_busy); end
        do_pause();
        pulse_eoc();
        resp_ready = 1'b1;
        trigger();
        total++; if (tx_go !== 1'b1) begin bad++; $display("FAIL second_reply_go: got %b expected 1", tx_go); end
        resp_ready = 1'b0;
        finish_tx();
    endtask

    initial begin
        rst_n       = 1'b0;
        pause_n     = 1'b1;
        rx_eoc      = 1'b0;
        rx_error    = 1'b0;
        fdt_trigger = 1'b0;
        resp_ready  = 1'b0;
        tx_done     = 1'b0;
        test_reset();
        test_nominal();
        test_mid_tx_reset();
        test_late();
        test_timeout();
        test_last_grid_ready();
        test_pause_in_grid();
        test_eoc_with_pause();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
